// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hsync/vsync, tracks lock
// over consecutive well-formed frames and flags malformed lines/frames.
//
// state   | meaning
// SEARCH  | no frame reference yet, waiting for the first frame boundary
// ACQUIRE | counting error-free frame boundaries toward lock
// LOCKED  | timing confirmed, visible pixels are reported as valid
module vga_sync_decoder #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err
);

  localparam int H_TOT   = H_SW + H_BP + H_VIS + H_FP;
  localparam int V_TOT   = V_SW + V_BP + V_VIS + V_FP;
  localparam int H_START = H_SW + H_BP;
  localparam int V_START = V_SW + V_BP;

  localparam logic [11:0] H_TOT_C   = 12'(H_TOT);
  localparam logic [11:0] V_TOT_C   = 12'(V_TOT);
  localparam logic [10:0] H_START_C = 11'(H_START);
  localparam logic [10:0] H_END_C   = 11'(H_START + H_VIS);
  localparam logic [10:0] V_START_C = 11'(V_START);
  localparam logic [10:0] V_END_C   = 11'(V_START + V_VIS);
  localparam logic [10:0] CNT_MAX   = 11'h7FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  good_frames, good_frames_n;
  logic        hs1, hs2, vs1, vs2;
  logic [11:0] rgb1;
  logic [10:0] h_cnt, v_cnt, h_next, v_next, x_next, y_next;
  logic        v_pend, v_pend_eff;
  logic        h_fall, v_fall, v_zero;
  logic [11:0] h_len, v_len;
  logic        checking, h_err_c, v_err_c, in_vis, valid_next;

  // Edge detection and position of the pixel now held in stage 1.
  // A pending or simultaneous vsync edge is consumed by the hsync edge.
  always_comb begin
    h_fall     = hs2 & ~hs1;
    v_fall     = vs2 & ~vs1;
    v_pend_eff = v_pend | v_fall;
    v_zero     = h_fall & v_pend_eff;
    h_len      = {1'b0, h_cnt} + 12'd1;
    v_len      = {1'b0, v_cnt} + 12'd1;
    h_next     = h_cnt;
    v_next     = v_cnt;
    if (h_fall) begin
      h_next = '0;
    end else if (h_cnt != CNT_MAX) begin
      h_next = h_cnt + 11'd1;
    end
    if (v_zero) begin
      v_next = '0;
    end else if (h_fall && (v_cnt != CNT_MAX)) begin
      v_next = v_cnt + 11'd1;
    end
    checking   = (state != SEARCH);
    h_err_c    = checking & h_fall & (h_len != H_TOT_C);
    v_err_c    = checking & v_zero & (v_len != V_TOT_C);
    in_vis     = (h_next >= H_START_C) && (h_next < H_END_C) &&
                 (v_next >= V_START_C) && (v_next < V_END_C);
    x_next     = h_next - H_START_C;
    y_next     = v_next - V_START_C;
    valid_next = in_vis & (state == LOCKED);
  end

  // Lock FSM next-state: errors always restart the good-frame count.
  always_comb begin
    state_n       = state;
    good_frames_n = good_frames;
    case (state)
      SEARCH: begin
        good_frames_n = '0;
        if (v_zero) state_n = ACQUIRE;
      end
      ACQUIRE: begin
        if (h_err_c || v_err_c) begin
          good_frames_n = '0;
        end else if (v_zero) begin
          good_frames_n = good_frames + 2'd1;
          if (good_frames == 2'd1) state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (h_err_c || v_err_c) begin
          state_n       = ACQUIRE;
          good_frames_n = '0;
        end
      end
      default: begin
        state_n       = SEARCH;
        good_frames_n = '0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good_frames <= '0;
    end else begin
      state       <= state_n;
      good_frames <= good_frames_n;
    end
  end

  // Input sampling (stage 1) and edge-reference registers (stage 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1  <= 1'b1;
      hs2  <= 1'b1;
      vs1  <= 1'b1;
      vs2  <= 1'b1;
      rgb1 <= '0;
    end else begin
      hs1  <= hsync;
      hs2  <= hs1;
      vs1  <= vsync;
      vs2  <= vs1;
      rgb1 <= rgb_in;
    end
  end

  // Line/frame counters; h_cnt/v_cnt track the pixel presented on pix_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      v_pend <= 1'b0;
    end else begin
      h_cnt  <= h_next;
      v_cnt  <= v_next;
      v_pend <= h_fall ? 1'b0 : v_pend_eff;
    end
  end

  // Pixel outputs and error pulses; coordinates hold outside the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      pix_rgb     <= rgb1;
      pix_valid   <= valid_next;
      frame_start <= valid_next && (x_next == 11'd0) && (y_next == 11'd0);
      h_err       <= h_err_c;
      v_err       <= v_err_c;
      if (in_vis) begin
        pix_x <= x_next;
        pix_y <= y_next;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 16x11 raster so whole
// frames stay short. A free-running monitor accumulates pixel/pulse events;
// the main sequence compares those against hand-derived expectations.
module tb_vga_sync_decoder;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HS + HB + HV + HF;  // 16
  localparam int VT = VS + VB + VV + VF;  // 11
  localparam int HST = HS + HB;           // 6
  localparam int VST = VS + VB;           // 4

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] rgb_in = '0;
  logic [10:0] pix_x, pix_y;
  logic        pix_valid;
  logic [11:0] pix_rgb;
  logic        frame_start, locked, h_err, v_err;

  vga_sync_decoder #(
    .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err)
  );

  always #5 clk = ~clk;

  // generator view of the pixel currently driven
  bit          g_vis = 1'b0;
  int          g_x = 0, g_y = 0;
  logic [11:0] g_rgb = '0;
  // same, delayed by two clock edges
  bit          e_vis1 = 1'b0, e_vis2 = 1'b0;
  int          e_x1 = 0, e_x2 = 0, e_y1 = 0, e_y2 = 0;
  logic [11:0] e_rgb1 = '0, e_rgb2 = '0;

  int cyc = 0, n_valid = 0, n_bad = 0, n_fs = 0, n_herr = 0, n_verr = 0;
  int rise_cyc = -1, fall_cyc = -1, herr_cyc = -2, verr_cyc = -2;
  bit locked_q = 1'b0;
  bit expect_lock = 1'b0;

  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    e_vis1 <= g_vis;  e_vis2 <= e_vis1;
    e_x1   <= g_x;    e_x2   <= e_x1;
    e_y1   <= g_y;    e_y2   <= e_y1;
    e_rgb1 <= g_rgb;  e_rgb2 <= e_rgb1;
  end

  always @(negedge clk) begin
    if (pix_valid) begin
      n_valid <= n_valid + 1;
      if (!(e_vis2 && (int'(pix_x) == e_x2) && (int'(pix_y) == e_y2) && (pix_rgb == e_rgb2)))
        n_bad <= n_bad + 1;
    end
    if (expect_lock && e_vis2 && !pix_valid) n_bad <= n_bad + 1;
    if (frame_start) begin
      n_fs <= n_fs + 1;
      if (!(pix_valid && pix_x == 11'd0 && pix_y == 11'd0)) n_bad <= n_bad + 1;
    end
    if (h_err) begin n_herr <= n_herr + 1; herr_cyc <= cyc; end
    if (v_err) begin n_verr <= n_verr + 1; verr_cyc <= cyc; end
    if (locked && !locked_q) rise_cyc <= cyc;
    if (!locked && locked_q) fall_cyc <= cyc;
    locked_q <= locked;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cycle(input bit hs, input bit vs, input int h, input int v);
    logic [31:0] tx, ty;
    tx     = h - HST;
    ty     = v - VST;
    hsync  = hs;
    vsync  = vs;
    g_x    = h - HST;
    g_y    = v - VST;
    g_vis  = (h >= HST) && (h < HST + HV) && (v >= VST) && (v < VST + VV);
    rgb_in = {tx[5:0], ty[5:0]};
    g_rgb  = rgb_in;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int len, input int v);
    for (int i = 0; i < len; i++)
      drive_cycle((i < HS) ? 1'b0 : 1'b1, (v < VS) ? 1'b0 : 1'b1, i, v);
  endtask

  task automatic drive_lines(input int first, input int last, input int short_line, input int short_len);
    for (int l = first; l <= last; l++)
      drive_line((l == short_line) ? short_len : HT, l);
  endtask

  task automatic drive_frame(input int nlines, input int short_line, input int short_len);
    drive_lines(0, nlines - 1, short_line, short_len);
  endtask

  int f3_cyc, b_herr, b_verr, b_valid, b_fs;

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_pix_rgb", int'(pix_rgb), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_h_err", int'(h_err), 0);
    chk("rst_v_err", int'(v_err), 0);
    rst = 1'b0;

    // acquisition: two complete error-free frames, lock at third frame start
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("lock_not_yet", int'(locked), 0);
    f3_cyc = cyc;
    drive_frame(VT, -1, 0);
    chk("lock_after_f3", int'(locked), 1);
    chk("lock_rise_cycle", rise_cyc, f3_cyc + 2);

    // locked frame with coordinate-unique colour pattern
    b_valid = n_valid;
    b_fs    = n_fs;
    expect_lock = 1'b1;
    drive_frame(VT, -1, 0);
    expect_lock = 1'b0;
    chk("valid_pixels_f4", n_valid - b_valid, HV * VV);
    chk("frame_start_f4", n_fs - b_fs, 1);
    chk("pixel_errors_f4", n_bad, 0);
    chk("hold_pix_x", int'(pix_x), HV - 1);
    chk("hold_pix_y", int'(pix_y), VV - 1);
    chk("blank_pix_valid", int'(pix_valid), 0);
    chk("no_h_err_nominal", n_herr, 0);
    chk("no_v_err_nominal", n_verr, 0);

    // one short line while locked
    b_herr = n_herr;
    b_verr = n_verr;
    drive_frame(VT, 5, HT - 1);
    drive_frame(VT, -1, 0);
    chk("short_line_h_err", n_herr - b_herr, 1);
    chk("short_line_no_v_err", n_verr - b_verr, 0);
    chk("h_err_drops_lock", herr_cyc, fall_cyc);
    chk("unlocked_after_h_err", int'(locked), 0);
    drive_frame(VT, -1, 0);
    chk("relock_after_h_err", int'(locked), 1);

    // one short frame while locked
    b_herr = n_herr;
    b_verr = n_verr;
    drive_frame(VT - 1, -1, 0);
    drive_frame(VT, -1, 0);
    chk("short_frame_v_err", n_verr - b_verr, 1);
    chk("short_frame_no_h_err", n_herr - b_herr, 0);
    chk("v_err_drops_lock", verr_cyc, fall_cyc);
    chk("unlocked_after_v_err", int'(locked), 0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("relock_after_v_err", int'(locked), 1);

    // asynchronous reset in the middle of a visible line
    drive_lines(0, 6, -1, 0);
    for (int i = 0; i < 10; i++) drive_cycle((i < HS) ? 1'b0 : 1'b1, 1'b1, i, 7);
    rst = 1'b1;
    #1;
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_pix_valid", int'(pix_valid), 0);
    chk("async_rst_pix_x", int'(pix_x), 0);
    chk("async_rst_pix_y", int'(pix_y), 0);
    chk("async_rst_pix_rgb", int'(pix_rgb), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    b_herr = n_herr;
    b_verr = n_verr;
    drive_lines(8, VT - 1, -1, 0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("no_lock_two_frames_after_rst", int'(locked), 0);
    drive_frame(VT, -1, 0);
    chk("relock_after_rst", int'(locked), 1);
    chk("no_err_after_rst", (n_herr - b_herr) + (n_verr - b_verr), 0);
    chk("pixel_errors_total", n_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16; parameter H_SW, default 96; parameter H_BP, default 48, horizontal porch and sync widths in clocks.
REQ-003 The block SHALL have parameter V_VIS, default 480; V_FP, default 10; V_SW, default 2; V_BP, default 33, vertical porch and sync widths in lines.
REQ-004 The block SHALL have port clk, input, 1, pixel clock; one clk cycle equals one pixel period.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have ports hsync and vsync, input, 1 each, active-low sync from a VGA transmitter on the same clk.
REQ-007 The block SHALL have port rgb_in, input, 12, pixel colour {R4,G4,B4}.
REQ-008 The block SHALL have ports pix_x and pix_y, output, 11 each, recovered visible coordinates.
REQ-009 The block SHALL have ports pix_valid (output, 1, pixel in visible area and locked) and pix_rgb (output, 12, registered rgb_in).
REQ-010 The block SHALL have ports frame_start (output, 1, one-cycle pulse), locked (output, 1), h_err and v_err (output, 1 each, one-cycle error pulses).

Function
REQ-011 hsync, vsync, rgb_in SHALL be registered once (stage 1); edge detection SHALL compare stage 1 with a second register (stage 2).
REQ-012 An hsync falling edge (stage2=1, stage1=0) SHALL set h_cnt to 0; otherwise h_cnt SHALL increment by 1, saturating at 2047.
REQ-013 H_TOT = H_SW+H_BP+H_VIS+H_FP (800); h_cnt visible window SHALL be [H_SW+H_BP, H_SW+H_BP+H_VIS), i.e. [144,784); pix_x = h_cnt-144.
REQ-014 A vsync falling edge SHALL set flag v_pend; the next hsync falling edge SHALL set v_cnt to 0 and clear v_pend; other hsync falling edges SHALL increment v_cnt, saturating at 2047.
REQ-015 V_TOT = 525; visible lines SHALL be v_cnt in [V_SW+V_BP, V_SW+V_BP+V_VIS), i.e. [35,515); pix_y = v_cnt-35.
REQ-016 pix_x, pix_y, pix_rgb, pix_valid SHALL be registered and correspond to the rgb_in sampled 2 clk edges earlier (fixed latency 2).
REQ-017 pix_x, pix_y SHALL hold their last value outside the visible window; pix_valid SHALL be 0 there.
REQ-018 h_err SHALL pulse on an hsync falling edge whose preceding line length (h_cnt+1) differs from H_TOT, only in states ACQUIRE or LOCKED.
REQ-019 v_err SHALL pulse when v_cnt is set to 0 and the preceding frame line count (v_cnt+1) differs from V_TOT, only in ACQUIRE or LOCKED.
REQ-020 FSM states SHALL be SEARCH, ACQUIRE, LOCKED.
REQ-021 SEARCH -> ACQUIRE on the first v_cnt-to-0 event; no errors flagged in SEARCH.
REQ-022 ACQUIRE: counter good_frames (2 bits) SHALL increment on each error-free v_cnt-to-0 event; at 2 -> LOCKED; any h_err/v_err SHALL clear good_frames and stay in ACQUIRE.
REQ-023 LOCKED: any h_err or v_err SHALL return to ACQUIRE with good_frames=0 in the same cycle the error pulses.
REQ-024 locked SHALL be 1 exactly while in LOCKED; pix_valid SHALL be gated by locked.
REQ-025 frame_start SHALL pulse for one cycle, aligned with pix_* outputs, when pix_x=0, pix_y=0 and pix_valid=1.
REQ-026 Simultaneous vsync and hsync falling edges in one cycle SHALL be treated as v_pend set then consumed by that same hsync edge (v_cnt=0).
REQ-027 A line with no hsync edge SHALL keep h_cnt saturated and report h_err on the next edge that arrives.

Reset
REQ-028 On rst=1, asynchronously: state=SEARCH, h_cnt=0, v_cnt=0, v_pend=0, good_frames=0, sync registers=1, rgb registers=0.
REQ-029 On rst=1: pix_x=0, pix_y=0, pix_rgb=0, pix_valid=0, frame_start=0, locked=0, h_err=0, v_err=0.
REQ-030 rst asserted mid-frame SHALL discard all lock progress; after release the block SHALL re-enter via SEARCH.

Verification
REQ-031 Drive 3 nominal 800x525 frames -> locked rises at start of frame 3's counting (after 2nd error-free frame end); h_err=v_err=0 throughout.
REQ-032 Locked, drive rgb_in=pixel-unique pattern {x[5:0],y[5:0]} -> pix_rgb matches pix_x/pix_y for all 307200 pixels, latency 2.
REQ-033 Locked, shorten one line to 799 clocks -> single h_err pulse, locked=0, relock after 2 good frames.
REQ-034 Locked, frame of 524 lines -> single v_err pulse, locked drops same cycle.
REQ-035 Assert rst for 3 cycles at line 200 -> all outputs 0 immediately; relock after 3 further frames.
REQ-036 Coincident hsync/vsync falling edges -> v_cnt=0 on that edge; frame_start pulses once per frame at pix_x=0,pix_y=0.
